// File: rtl/bcd2bin_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd2bin_pkg
// Shared definitions for the sequential BCD-to-binary converter:
//   - state_t    : converter FSM states (IDLE, CONV)
//   - DIGIT_W    : width of one packed BCD digit
//   - MAX_DIGIT  : largest legal BCD digit value
//   - clog2_dec  : minimum binary width able to hold any DIGITS-digit decimal
// Optional feature macro used by the files importing this package:
//   BCD2BIN_ERR_EN (invalid-digit error flag)
// ---------------------------------------------------------------------------
package bcd2bin_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    // Smallest w such that 2**w >= 10**digits, i.e. enough bits for 0..10**digits-1.
    function automatic int clog2_dec(input int digits);
        longint unsigned p;
        int              w;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        w = 0;
        for (int k = 0; k < 64; k++) begin
            if ((64'd1 << k) < p) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq_if
// Request/result bundle of the BCD-to-binary converter.
//   start : request a conversion (master -> slave)
//   bcd   : packed BCD word, digit i at [4i+3:4i], MSD on top (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse, bin/err valid (slave -> master)
//   bin   : binary result, held until the next done (slave -> master)
//   err   : some digit > 9 in the converted word; only with BCD2BIN_ERR_EN
// ---------------------------------------------------------------------------
interface bcd2bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      bin;
`ifdef BCD2BIN_ERR_EN
    logic                  err;
`endif

    modport master (
        output start,
        output bcd,
        input  busy,
        input  done,
`ifdef BCD2BIN_ERR_EN
        input  err,
`endif
        input  bin
    );

    modport slave (
        input  start,
        input  bcd,
        output busy,
        output done,
`ifdef BCD2BIN_ERR_EN
        output err,
`endif
        output bin
    );

endinterface

// File: rtl/bcd2bin_seq_mul10_add.sv
// ---------------------------------------------------------------------------
// mul10_add
// Combinational accumulate step: sum_o = acc_i*10 + d_i, truncated to WIDTH.
//   acc_i : running binary accumulator
//   d_i   : next BCD digit (raw value, 10..15 are not filtered)
//   sum_o : updated accumulator
// ---------------------------------------------------------------------------
module mul10_add #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [3:0]       d_i,
    output logic [WIDTH-1:0] sum_o
);

    // x*10 as x*8 + x*2 keeps this a pair of adders instead of a multiplier.
    assign sum_o = (acc_i << 3) + (acc_i << 1) + {{(WIDTH-4){1'b0}}, d_i};

endmodule

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
// Sequential BCD-to-binary converter, one digit per clock, MSD first
// (acc = acc*10 + digit). Result valid DIGITS edges after the start edge.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : bcd2bin_seq_if.slave (start, bcd in; busy, done, bin [, err] out)
// Optional feature macro: BCD2BIN_ERR_EN adds a sticky invalid-digit flag
// reported on err together with bin.
// ---------------------------------------------------------------------------
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic            clk,
    input  logic            rst,
    bcd2bin_seq_if.slave    bus
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SR_W  = DIGIT_W * DIGITS;

    generate
        if (WIDTH < clog2_dec(DIGITS)) begin : g_width_chk
            $error("bcd2bin_seq: WIDTH too small to hold DIGITS decimal digits");
        end
    endgenerate

    state_t              state_q;
    logic [SR_W-1:0]     shreg_q;
    logic [WIDTH-1:0]    acc_q;
    logic [WIDTH-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    bin_q;
    logic                done_q;
    logic                busy_q;
    logic [DIGIT_W-1:0]  digit;

    // Digits are consumed from the top of the shift register.
    assign digit = shreg_q[SR_W-1 -: DIGIT_W];

    mul10_add #(
        .WIDTH (WIDTH)
    ) u_mul10_add (
        .acc_i (acc_q),
        .d_i   (digit),
        .sum_o (acc_d)
    );

`ifdef BCD2BIN_ERR_EN
    logic err_q;
    logic err_sticky_q;
    logic digit_bad;

    assign digit_bad = (digit > MAX_DIGIT);
    assign bus.err   = err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BCD2BIN_ERR_EN
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shreg_q <= bus.bcd;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(DIGITS - 1);
                        busy_q  <= 1'b1;
                        state_q <= CONV;
`ifdef BCD2BIN_ERR_EN
                        err_sticky_q <= 1'b0;
`endif
                    end
                end
                CONV: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q << DIGIT_W;
                    cnt_q   <= cnt_q - 1'b1;
`ifdef BCD2BIN_ERR_EN
                    if (digit_bad) begin
                        err_sticky_q <= 1'b1;
                    end
`endif
                    if (cnt_q == '0) begin
                        // Last digit: publish the freshly accumulated value.
                        bin_q   <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef BCD2BIN_ERR_EN
                        err_q <= err_sticky_q | digit_bad;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bin  = bin_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin_seq
// Directed testbench for bcd2bin_seq (DIGITS=3, WIDTH=10). Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd2bin_seq;

    localparam int DIGITS = 3;
    localparam int WIDTH  = 10;

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    bcd2bin_seq_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    bcd2bin_seq #(
        .DIGITS (DIGITS),
        .WIDTH  (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Full conversion from an idle converter: start at one falling edge,
    // busy for DIGITS cycles, then a single-cycle done with the result.
    task automatic run_conv(input logic [11:0] bcd_val, input int exp_bin, input logic exp_err);
        bus.bcd   = bcd_val;
        bus.start = 1'b1;
        for (int i = 1; i <= DIGITS; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_eq("busy_during", 32'(bus.busy), 32'd1);
            check_eq("done_early", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        check_eq("done_pulse", 32'(bus.done), 32'd1);
        check_eq("busy_after", 32'(bus.busy), 32'd0);
        check_eq("bin", 32'(bus.bin), 32'(exp_bin));
`ifdef BCD2BIN_ERR_EN
        check_eq("err", 32'(bus.err), 32'(exp_err));
`else
        if (exp_err) begin
            // invalid digit in the word; flag not built in this configuration
        end
`endif
        @(negedge clk);
        check_eq("done_width", 32'(bus.done), 32'd0);
        check_eq("bin_hold", 32'(bus.bin), 32'(exp_bin));
        $display("conv bcd=%h -> bin=%0d (expected %0d)", bcd_val, bus.bin, exp_bin);
    endtask

    initial begin
        int pulses;
        int gaps;

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.bcd   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_bin", 32'(bus.bin), 32'd0);
`ifdef BCD2BIN_ERR_EN
        check_eq("rst_err", 32'(bus.err), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        run_conv(12'h255, 255, 1'b0);
        run_conv(12'h999, 999, 1'b0);
        run_conv(12'h000, 0, 1'b0);
        run_conv(12'h1A0, 200, 1'b1);
        run_conv(12'h042, 42, 1'b0);

        // A second start while busy is ignored; bcd change must not matter.
        bus.bcd   = 12'h321;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.bcd   = 12'h111;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("ign_done", 32'(bus.done), 32'd1);
        check_eq("ign_bin", 32'(bus.bin), 32'd321);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check_eq("ign_extra_done", 32'(pulses), 32'd0);
        $display("conv bcd=321 with ignored restart -> bin=%0d", bus.bin);

        // start held high: back-to-back conversions with no idle cycle.
        bus.bcd   = 12'h007;
        bus.start = 1'b1;
        @(negedge clk);
        bus.bcd = 12'h008;  // first conversion already latched 007
        pulses  = 0;
        gaps    = 0;
        for (int c = 1; c <= 2 * (DIGITS + 1); c++) begin
            if (c > 1) @(negedge clk);
            if (!bus.busy && !bus.done) gaps++;
            if (bus.done) begin
                pulses++;
                check_eq(pulses == 1 ? "b2b_bin_first" : "b2b_bin_second",
                         32'(bus.bin), pulses == 1 ? 32'd7 : 32'd8);
                $display("back-to-back result %0d bin=%0d", pulses, bus.bin);
            end
        end
        bus.start = 1'b0;
        check_eq("b2b_pulses", 32'(pulses), 32'd2);
        check_eq("b2b_gaps", 32'(gaps), 32'd0);
        repeat (DIGITS + 2) @(negedge clk);
        check_eq("b2b_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset between E1 and E2 of a conversion.
        bus.bcd   = 12'h255;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("mid_busy_pre", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_done", 32'(bus.done), 32'd0);
        check_eq("mid_rst_bin", 32'(bus.bin), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check_eq("mid_rst_quiet", 32'(pulses), 32'd0);
        $display("reset mid-conversion: bin=%0d busy=%0d", bus.bin, bus.busy);

        run_conv(12'h500, 500, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
